ef_i2c_reg_seq: RTL and testbench

- Register-access sequencer and arbiter in front of the I2C master's command and data streams (the same cmd/write/read FIFO interface the I2C bus wrapper exposes).
- Accepts single-byte register read/write requests from NUM_REQ requesters and grants them round-robin.
- Expands each granted request into the I2C command and data-byte sequence, then returns read data and error status to the granted requester.
- Sits between on-chip clients (e.g. a sensor poller and the CPU bridge) and one shared I2C master instance.

---
 rtl/ef_i2c_seq_pkg.sv | 29 ++
 rtl/ef_rr_arbiter.sv | 34 +++
 rtl/ef_i2c_reg_seq.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_ef_i2c_reg_seq.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ef_i2c_seq_pkg.sv
// ---------------------------------------------------------------------------
// ef_i2c_seq_pkg
// Shared types for the I2C register-access sequencer: sequencer state
// encoding, response error codes and the minimum WAIT dwell.
// ---------------------------------------------------------------------------
package ef_i2c_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD1  = 3'd1,
        DREG  = 3'd2,
        DVAL  = 3'd3,
        CMD2  = 3'd4,
        RDATA = 3'd5,
        WAIT  = 3'd6,
        DONE  = 3'd7
    } seq_state_e;

    typedef enum logic [1:0] {
        ERR_OK   = 2'b00,
        ERR_NACK = 2'b01,
        ERR_TMO  = 2'b10
    } seq_err_e;

    // The master's busy flag can lag the last stream beat, so WAIT ignores
    // it for this many cycles after entry.
    localparam int WAIT_MIN_CYC = 2;

endpackage

// File: rtl/ef_rr_arbiter.sv
// ---------------------------------------------------------------------------
// ef_rr_arbiter
// Combinational round-robin grant. Searches for the first set request bit
// starting one position above rr_ptr_i and wrapping around.
//   req_i    : request vector
//   rr_ptr_i : index of the previous winner
//   grant_o  : one-hot grant, all zero when no request is pending
// ---------------------------------------------------------------------------
module ef_rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   rr_ptr_i,
    output logic [NUM_REQ-1:0] grant_o
);

    logic [NUM_REQ-1:0] hi_mask;
    logic [NUM_REQ-1:0] req_hi;
    logic [NUM_REQ-1:0] pick;

    // Requests above the pointer win first; if none, fall back to the full
    // vector (wrap-around). Lowest set bit of the chosen vector is the grant.
    always_comb begin
        hi_mask = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            hi_mask[k] = (PTR_W'(k) > rr_ptr_i);
        end
        req_hi  = req_i & hi_mask;
        pick    = (req_hi != '0) ? req_hi : req_i;
        grant_o = pick & (~pick + NUM_REQ'(1));
    end

endmodule

// File: rtl/ef_i2c_reg_seq.sv
// ---------------------------------------------------------------------------
// ef_i2c_reg_seq
// Arbitrates single-byte register read/write requests from NUM_REQ clients
// and expands each into the I2C master's command / write-stream / read-stream
// sequence, then returns read data and error status to the requester.
//
// Ports
//   clk, rst_n                 : clock, async active-low reset
//   req_valid/we/dev_addr/
//   reg_addr/wdata             : per-requester request (packed vectors)
//   resp_valid/rdata/err       : one-hot completion pulse, read data, status
//   cmd_*                      : command stream to the I2C master
//   wr_*                       : write-data stream to the I2C master
//   rd_*                       : read-data stream from the I2C master
//   i2c_busy, i2c_missed_ack   : master status
//   seq_busy                   : sequencer not idle
//
// State      | meaning
// -----------+----------------------------------------------------------
// IDLE       | waiting for a request; arbitrate and latch on exit
// CMD1       | start + address; write_multiple+stop (wr) or write (rd)
// DREG       | register address byte
// DVAL       | write data byte (writes only)
// CMD2       | repeated start + read + stop (reads only)
// RDATA      | accept the read byte
// WAIT       | wait for the master to go idle (min dwell first)
// DONE       | one-cycle response pulse to the granted requester
// ---------------------------------------------------------------------------
module ef_i2c_reg_seq
    import ef_i2c_seq_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int TIMEOUT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_we,
    input  logic [7*NUM_REQ-1:0]   req_dev_addr,
    input  logic [8*NUM_REQ-1:0]   req_reg_addr,
    input  logic [8*NUM_REQ-1:0]   req_wdata,

    output logic [NUM_REQ-1:0]     resp_valid,
    output logic [7:0]             resp_rdata,
    output logic [1:0]             resp_err,

    output logic [6:0]             cmd_address,
    output logic                   cmd_start,
    output logic                   cmd_read,
    output logic                   cmd_write,
    output logic                   cmd_write_multiple,
    output logic                   cmd_stop,
    output logic                   cmd_valid,
    input  logic                   cmd_ready,

    output logic [7:0]             wr_tdata,
    output logic                   wr_tvalid,
    output logic                   wr_tlast,
    input  logic                   wr_tready,

    input  logic [7:0]             rd_tdata,
    input  logic                   rd_tvalid,
    output logic                   rd_tready,

    input  logic                   i2c_busy,
    input  logic                   i2c_missed_ack,

    output logic                   seq_busy
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [TIMEOUT_W-1:0] TMO_MAX = '1;

    seq_state_e           state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic                 we_q, we_d;
    logic [6:0]           dev_q, dev_d;
    logic [7:0]           reg_q, reg_d;
    logic [7:0]           wdata_q, wdata_d;
    logic [7:0]           rdcap_q, rdcap_d;
    logic [7:0]           rdata_q, rdata_d;
    logic [1:0]           err_q, err_d;
    logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    logic [NUM_REQ-1:0]   arb_grant;
    logic [PTR_W-1:0]     arb_idx;
    logic                 sel_we;
    logic [6:0]           sel_dev;
    logic [7:0]           sel_reg;
    logic [7:0]           sel_wdata;
    logic                 tmo_fire;
    logic                 start_txn;

    ef_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_i    (req_valid),
        .rr_ptr_i (rr_ptr_q),
        .grant_o  (arb_grant)
    );

    // Encode the winner and pick its request fields.
    always_comb begin
        arb_idx   = '0;
        sel_we    = 1'b0;
        sel_dev   = '0;
        sel_reg   = '0;
        sel_wdata = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (arb_grant[k]) begin
                arb_idx   = PTR_W'(k);
                sel_we    = req_we[k];
                sel_dev   = req_dev_addr[k*7 +: 7];
                sel_reg   = req_reg_addr[k*8 +: 8];
                sel_wdata = req_wdata[k*8 +: 8];
            end
        end
    end

    assign start_txn = (state_q == IDLE) && (|req_valid);

    // Fires on the edge where the watchdog would reach all-ones; it takes
    // priority over any handshake in the same cycle.
    assign tmo_fire = (state_q != IDLE) && (state_q != DONE) &&
                      ((tmo_cnt_q + TIMEOUT_W'(1)) == TMO_MAX);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req_valid) state_d = CMD1;
            CMD1:    if (cmd_ready)  state_d = DREG;
            DREG:    if (wr_tready)  state_d = we_q ? DVAL : CMD2;
            DVAL:    if (wr_tready)  state_d = WAIT;
            CMD2:    if (cmd_ready)  state_d = RDATA;
            RDATA:   if (rd_tvalid)  state_d = WAIT;
            WAIT:    if ((tmo_cnt_q >= TIMEOUT_W'(WAIT_MIN_CYC)) && !i2c_busy)
                         state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (tmo_fire) begin
            state_d = DONE;
        end
    end

    // ---------------- output logic ----------------
    // Every output is decoded from registered state and latched fields only.
    always_comb begin
        cmd_address        = '0;
        cmd_start          = 1'b0;
        cmd_read           = 1'b0;
        cmd_write          = 1'b0;
        cmd_write_multiple = 1'b0;
        cmd_stop           = 1'b0;
        cmd_valid          = 1'b0;
        wr_tdata           = '0;
        wr_tvalid          = 1'b0;
        wr_tlast           = 1'b0;
        rd_tready          = 1'b0;
        resp_valid         = '0;
        resp_err           = '0;
        case (state_q)
            CMD1: begin
                cmd_valid          = 1'b1;
                cmd_address        = dev_q;
                cmd_start          = 1'b1;
                cmd_write_multiple = we_q;
                cmd_write          = ~we_q;
                cmd_stop           = we_q;
            end
            DREG: begin
                wr_tvalid = 1'b1;
                wr_tdata  = reg_q;
                wr_tlast  = ~we_q;
            end
            DVAL: begin
                wr_tvalid = 1'b1;
                wr_tdata  = wdata_q;
                wr_tlast  = 1'b1;
            end
            CMD2: begin
                cmd_valid   = 1'b1;
                cmd_address = dev_q;
                cmd_start   = 1'b1;
                cmd_read    = 1'b1;
                cmd_stop    = 1'b1;
            end
            RDATA: begin
                rd_tready = 1'b1;
            end
            DONE: begin
                resp_valid = grant_q;
                resp_err   = err_q;
            end
            default: ;
        endcase
    end

    assign resp_rdata = rdata_q;
    assign seq_busy   = (state_q != IDLE);

    // ---------------- datapath ----------------
    always_comb begin
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        we_d      = we_q;
        dev_d     = dev_q;
        reg_d     = reg_q;
        wdata_d   = wdata_q;
        rdcap_d   = rdcap_q;
        rdata_d   = rdata_q;
        err_d     = err_q;

        if (start_txn) begin
            grant_d  = arb_grant;
            rr_ptr_d = arb_idx;
            we_d     = sel_we;
            dev_d    = sel_dev;
            reg_d    = sel_reg;
            wdata_d  = sel_wdata;
            rdcap_d  = '0;
            err_d    = ERR_OK;
        end

        // Missed ACK is only recorded; the master finishes the bus sequence
        // on its own, so the stream sequence carries on unchanged.
        if (state_q != IDLE) begin
            if (tmo_fire) begin
                err_d = ERR_TMO;
            end else if (i2c_missed_ack && (err_q != ERR_TMO)) begin
                err_d = ERR_NACK;
            end
        end

        if ((state_q == RDATA) && rd_tvalid) begin
            rdcap_d = rd_tdata;
        end

        // Response data is loaded on DONE entry and held until the next DONE.
        if ((state_d == DONE) && (state_q != DONE)) begin
            rdata_d = we_q ? 8'h00 : rdcap_q;
        end

        if ((state_d != state_q) || (state_q == IDLE)) begin
            tmo_cnt_d = '0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + TIMEOUT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q   <= '0;
            rr_ptr_q  <= PTR_W'(NUM_REQ - 1);
            we_q      <= 1'b0;
            dev_q     <= '0;
            reg_q     <= '0;
            wdata_q   <= '0;
            rdcap_q   <= '0;
            rdata_q   <= '0;
            err_q     <= ERR_OK;
            tmo_cnt_q <= '0;
        end else begin
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            we_q      <= we_d;
            dev_q     <= dev_d;
            reg_q     <= reg_d;
            wdata_q   <= wdata_d;
            rdcap_q   <= rdcap_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

endmodule

// File: tb/tb_ef_i2c_reg_seq.sv
// ---------------------------------------------------------------------------
// tb_ef_i2c_reg_seq
// Scoreboard bench: each request pushes its expected command beats, write
// beats and response onto queues; a negedge monitor pops and compares them
// as the DUT handshakes them out.
// ---------------------------------------------------------------------------
module tb_ef_i2c_reg_seq;

    localparam int NR = 2;
    localparam int TW = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_we = '0;
    logic [7*NR-1:0]   req_dev_addr = '0;
    logic [8*NR-1:0]   req_reg_addr = '0;
    logic [8*NR-1:0]   req_wdata = '0;
    logic [NR-1:0]     resp_valid;
    logic [7:0]        resp_rdata;
    logic [1:0]        resp_err;
    logic [6:0]        cmd_address;
    logic              cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop;
    logic              cmd_valid;
    logic              cmd_ready = 1'b1;
    logic [7:0]        wr_tdata;
    logic              wr_tvalid, wr_tlast;
    logic              wr_tready = 1'b1;
    logic [7:0]        rd_tdata = 8'h5E;
    logic              rd_tvalid = 1'b1;
    logic              rd_tready;
    logic              i2c_busy = 1'b0;
    logic              i2c_missed_ack = 1'b0;
    logic              seq_busy;

    always #5 clk = ~clk;

    ef_i2c_reg_seq #(.NUM_REQ(NR), .TIMEOUT_W(TW)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .req_valid          (req_valid),
        .req_we             (req_we),
        .req_dev_addr       (req_dev_addr),
        .req_reg_addr       (req_reg_addr),
        .req_wdata          (req_wdata),
        .resp_valid         (resp_valid),
        .resp_rdata         (resp_rdata),
        .resp_err           (resp_err),
        .cmd_address        (cmd_address),
        .cmd_start          (cmd_start),
        .cmd_read           (cmd_read),
        .cmd_write          (cmd_write),
        .cmd_write_multiple (cmd_write_multiple),
        .cmd_stop           (cmd_stop),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .wr_tdata           (wr_tdata),
        .wr_tvalid          (wr_tvalid),
        .wr_tlast           (wr_tlast),
        .wr_tready          (wr_tready),
        .rd_tdata           (rd_tdata),
        .rd_tvalid          (rd_tvalid),
        .rd_tready          (rd_tready),
        .i2c_busy           (i2c_busy),
        .i2c_missed_ack     (i2c_missed_ack),
        .seq_busy           (seq_busy)
    );

    int n_vec  = 0;
    int n_miss = 0;
    int tmo_cyc;
    bit done_flag = 1'b0;

    logic [11:0] exp_cmd[$];
    logic [8:0]  exp_wr[$];
    logic [11:0] exp_resp[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] mk_cmd(input logic [6:0] a, input logic st,
                                           input logic rd, input logic wr,
                                           input logic wm, input logic sp);
        return {a, st, rd, wr, wm, sp};
    endfunction

    function automatic logic [63:0] all_outs();
        return 64'({resp_valid, resp_rdata, resp_err, cmd_address, cmd_start,
                    cmd_read, cmd_write, cmd_write_multiple, cmd_stop, cmd_valid,
                    wr_tdata, wr_tvalid, wr_tlast, rd_tready, seq_busy});
    endfunction

    // Monitor: every handshake is popped against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd_valid && cmd_ready) begin
                if (exp_cmd.size() == 0) chk("cmd_unexp", 64'(exp_cmd.size()), 64'd1);
                else chk("cmd", 64'({cmd_address, cmd_start, cmd_read, cmd_write,
                                      cmd_write_multiple, cmd_stop}), 64'(exp_cmd.pop_front()));
            end
            if (wr_tvalid && wr_tready) begin
                if (exp_wr.size() == 0) chk("wr_unexp", 64'(exp_wr.size()), 64'd1);
                else chk("wr", 64'({wr_tlast, wr_tdata}), 64'(exp_wr.pop_front()));
            end
            if (resp_valid != '0) begin
                if (exp_resp.size() == 0) chk("resp_unexp", 64'(exp_resp.size()), 64'd1);
                else chk("resp", 64'({resp_valid, resp_rdata, resp_err}), 64'(exp_resp.pop_front()));
            end
        end
    end

    task automatic set_req(input int idx, input logic we, input logic [6:0] dev,
                           input logic [7:0] ra, input logic [7:0] wd);
        req_we[idx]              = we;
        req_dev_addr[idx*7 +: 7] = dev;
        req_reg_addr[idx*8 +: 8] = ra;
        req_wdata[idx*8 +: 8]    = wd;
    endtask

    task automatic push_exp(input int idx, input logic we, input logic [6:0] dev,
                            input logic [7:0] ra, input logic [7:0] wd,
                            input logic [1:0] err, input bit tmo);
        logic [NR-1:0] oh;
        oh = NR'(1) << idx;
        if (!tmo) begin
            if (we) begin
                exp_cmd.push_back(mk_cmd(dev, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
                exp_wr.push_back({1'b0, ra});
                exp_wr.push_back({1'b1, wd});
            end else begin
                exp_cmd.push_back(mk_cmd(dev, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
                exp_wr.push_back({1'b1, ra});
                exp_cmd.push_back(mk_cmd(dev, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
            end
        end
        exp_resp.push_back({oh, (we || tmo) ? 8'h00 : rd_tdata, err});
    endtask

    task automatic wait_resp(input logic [NR-1:0] oh);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if ((resp_valid & oh) != '0) seen = 1'b1;
        end
        if (!seen) chk("resp_timeout", 64'(resp_valid), 64'(oh));
    endtask

    task automatic do_req(input int idx, input logic we, input logic [6:0] dev,
                          input logic [7:0] ra, input logic [7:0] wd,
                          input logic [1:0] err, input bit tmo);
        push_exp(idx, we, dev, ra, wd, err, tmo);
        set_req(idx, we, dev, ra, wd);
        req_valid[idx] = 1'b1;
        wait_resp(NR'(1) << idx);
        @(posedge clk); #1;
        req_valid[idx] = 1'b0;
    endtask

    // Both requesters held continuously: grants must alternate from 0.
    task automatic alt(input int n);
        set_req(0, 1'b1, 7'h21, 8'h30, 8'h11);
        set_req(1, 1'b0, 7'h22, 8'h31, 8'h00);
        for (int k = 0; k < n; k++) begin
            if (k % 2 == 0) push_exp(0, 1'b1, 7'h21, 8'h30, 8'h11, 2'b00, 1'b0);
            else            push_exp(1, 1'b0, 7'h22, 8'h31, 8'h00, 2'b00, 1'b0);
        end
        req_valid = '1;
        for (int k = 0; k < n; k++) wait_resp('1);
        @(posedge clk); #1;
        req_valid = '0;
    endtask

    initial begin
        #200000;
        if (!done_flag) begin
            $display("FAIL global_timeout: observed running expected finished");
            $fatal(1, "bench timeout");
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_outs", all_outs(), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_outs", all_outs(), 64'd0);
        @(posedge clk); #1;

        // plain write then plain read
        do_req(0, 1'b1, 7'h50, 8'h12, 8'hA5, 2'b00, 1'b0);
        rd_tdata = 8'h5E;
        do_req(1, 1'b0, 7'h3C, 8'h07, 8'h00, 2'b00, 1'b0);
        repeat (3) @(negedge clk);
        chk("rdata_hold", 64'(resp_rdata), 64'h5E);
        @(posedge clk); #1;

        rd_tdata = 8'hC3;
        alt(4);

        // missed ACK during the register byte of a write
        fork
            do_req(0, 1'b1, 7'h1A, 8'h40, 8'h99, 2'b01, 1'b0);
            begin
                bit hit;
                hit = 1'b0;
                for (int i = 0; i < 50 && !hit; i++) begin
                    @(negedge clk);
                    if (wr_tvalid && !wr_tlast) begin
                        hit = 1'b1;
                        i2c_missed_ack = 1'b1;
                        @(posedge clk); #1;
                        i2c_missed_ack = 1'b0;
                    end
                end
            end
        join

        // master reports busy: sequencer must sit in WAIT until it clears
        i2c_busy = 1'b1;
        fork
            do_req(1, 1'b1, 7'h2B, 8'h55, 8'h66, 2'b00, 1'b0);
            begin
                repeat (8) @(negedge clk);
                chk("wait_busy", 64'(seq_busy), 64'd1);
                @(posedge clk); #1;
                i2c_busy = 1'b0;
            end
        join

        // command stream stalled: watchdog expires
        cmd_ready = 1'b0;
        tmo_cyc = 0;
        fork
            do_req(0, 1'b1, 7'h60, 8'h01, 8'h02, 2'b10, 1'b1);
            begin
                repeat (40) begin
                    @(negedge clk);
                    if (cmd_valid) tmo_cyc++;
                end
            end
        join
        chk("tmo_len", 64'(tmo_cyc), 64'd15);
        chk("tmo_idle", 64'({cmd_valid, seq_busy}), 64'd0);
        cmd_ready = 1'b1;
        @(posedge clk); #1;

        // reset while waiting for read data
        rd_tvalid = 1'b0;
        set_req(0, 1'b0, 7'h44, 8'h09, 8'h00);
        exp_cmd.push_back(mk_cmd(7'h44, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        exp_wr.push_back({1'b1, 8'h09});
        exp_cmd.push_back(mk_cmd(7'h44, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
        req_valid[0] = 1'b1;
        for (int i = 0; i < 50 && !rd_tready; i++) @(negedge clk);
        chk("rst_reach", 64'(rd_tready), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outs", all_outs(), 64'd0);
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rd_tvalid = 1'b1;
        chk("rst_cmdq", 64'(exp_cmd.size()), 64'd0);
        chk("rst_wrq", 64'(exp_wr.size()), 64'd0);

        rd_tdata = 8'h7A;
        alt(2);

        repeat (5) @(negedge clk);
        chk("end_cmdq", 64'(exp_cmd.size()), 64'd0);
        chk("end_wrq", 64'(exp_wr.size()), 64'd0);
        chk("end_respq", 64'(exp_resp.size()), 64'd0);

        done_flag = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
